// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: opcode values, PC next-address
// select codes and the sequencer state encoding.
// Imported by pc_sequencer and pc_seq_decode.
package pc_sequencer_pkg;

    // Opcodes live in instr[15:13]
    localparam logic [2:0] OP_ALU0 = 3'b000;
    localparam logic [2:0] OP_ALU1 = 3'b001;
    localparam logic [2:0] OP_ALU2 = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    // PC next-address select
    localparam logic [2:0] PC_SEL_INC = 3'b000;
    localparam logic [2:0] PC_SEL_IMM = 3'b110;
    localparam logic [2:0] PC_SEL_ALU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALTED  = 3'd6
    } state_e;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode classifier for the PC sequencer.
// Ports: opcode in; is_mem, is_store, is_branch, is_jalr, is_halt, writes_reg out.
// Zero latency, no state.
module pc_seq_decode
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jalr,
    output logic       is_halt,
    output logic       writes_reg
);

    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jalr    = 1'b0;
        is_halt    = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_ALU0, OP_ALU1, OP_ALU2: writes_reg = 1'b1;
            OP_HALT: is_halt = 1'b1;
            OP_LW: begin
                is_mem     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BEQ: is_branch = 1'b1;
            OP_JALR: begin
                is_jalr    = 1'b1;
                writes_reg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB per instruction,
// 4 cycles minimum (5 for LW/SW); each cycle without imem_ready/dmem_ready stalls 1.
// Ports: clk, reset (async, active-high), instr/imem_ready/dmem_ready/alu_zero in;
// imem_req, dmem_req, dmem_we, ir_out, reg_we, pc_en, pc_sel, halted out.
// Optional: define INSTR_COUNT_EN to add the 16-bit wrapping instr_count output.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] ir_out,
    output logic        reg_we,
    output logic        pc_en,
    output logic [2:0]  pc_sel,
    output logic        halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        taken_q, taken_d;

    logic is_mem, is_store, is_branch, is_jalr, is_halt, writes_reg;

    // Decode always looks at the latched instruction, which is stable from
    // DECODE through WB.
    pc_seq_decode u_decode (
        .opcode     (ir_q[15:13]),
        .is_mem     (is_mem),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jalr    (is_jalr),
        .is_halt    (is_halt),
        .writes_reg (writes_reg)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = is_halt ? ST_HALTED : ST_EXEC;
            ST_EXEC:   state_d = is_mem ? ST_MEM : ST_WB;
            ST_MEM:    if (dmem_ready) state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs depend on state only, so async reset clears them immediately.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_INC;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            ST_WB: begin
                pc_en  = 1'b1;
                reg_we = writes_reg;
                if (taken_q) begin
                    pc_sel = PC_SEL_IMM;
                end else if (is_jalr) begin
                    pc_sel = PC_SEL_ALU;
                end
            end
            ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: the IR loads only on the accepting FETCH edge,
    // the branch flag is captured at the end of EXEC where alu_zero is valid.
    always_comb begin
        ir_d    = ir_q;
        taken_d = taken_q;
        if (state_q == ST_FETCH && imem_ready) begin
            ir_d = instr;
        end
        if (state_q == ST_EXEC) begin
            taken_d = is_branch & alu_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q    <= 16'h0000;
            taken_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            taken_q <= taken_d;
        end
    end

    assign ir_out = ir_q;

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    // Counts retired instructions; natural 16-bit wrap.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_WB) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        imem_ready, dmem_ready, alu_zero;
    logic        imem_req, dmem_req, dmem_we, reg_we, pc_en, halted;
    logic [15:0] ir_out;
    logic [2:0]  pc_sel;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .alu_zero   (alu_zero),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_out     (ir_out),
        .reg_we     (reg_we),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .halted     (halted)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        reg_we;
        logic        pc_en;
        logic [2:0]  pc_sel;
        logic        halted;
        logic [15:0] ir;
        logic [15:0] cnt;
    } outv_t;

    outv_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_ir  = 16'h0000;
    logic [15:0] m_cnt = 16'h0000;
    logic        drain_req = 1'b0;
    logic        drain_done = 1'b0;

    function automatic outv_t mk(input logic req, input logic dreq, input logic we,
                                 input logic rwe, input logic pcen,
                                 input logic [2:0] sel, input logic halt);
        outv_t v;
        v.imem_req = req;
        v.dmem_req = dreq;
        v.dmem_we  = we;
        v.reg_we   = rwe;
        v.pc_en    = pcen;
        v.pc_sel   = sel;
        v.halted   = halt;
        v.ir       = m_ir;
        v.cnt      = m_cnt;
        return v;
    endfunction

    // One clock cycle: expected outputs for the cycle just started, and the
    // inputs that the DUT samples at the end of it.
    task automatic cyc(input outv_t e, input logic ir_rdy, input logic dm_rdy,
                       input logic az, input logic [15:0] ins, input logic rst);
        @(posedge clk);
        #1;
        reset      = rst;
        imem_ready = ir_rdy;
        dmem_ready = dm_rdy;
        alu_zero   = az;
        instr      = ins;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [15:0] ins, input int iw);
        for (int i = 0; i <= iw; i++) begin
            cyc(mk(1, 0, 0, 0, 0, 3'b000, 0), (i == iw), 1'b0, 1'b0,
                (i == iw) ? ins : ~ins, 1'b0);
        end
        m_ir = ins;
    endtask

    // Stray ready pulses and junk instr words are driven in states that must ignore them.
    task automatic run(input logic [15:0] ins, input int iw, input int dw, input logic az,
                       input logic mem, input logic store, input logic rwe,
                       input logic [2:0] sel);
        fetch(ins, iw);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0); // DECODE
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b1, 1'b0, az, 16'hFFFF, 1'b0);   // EXEC
        if (mem) begin
            for (int j = 0; j <= dw; j++) begin
                cyc(mk(0, 1, store, 0, 0, 3'b000, 0), 1'b1, (j == dw), 1'b0, 16'hFFFF, 1'b0);
            end
        end
        cyc(mk(0, 0, 0, rwe, 1, sel, 0), 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);   // WB
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic halt_seq(input logic [15:0] ins);
        fetch(ins, 0);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); // DECODE
        for (int k = 0; k < 5; k++) begin
            cyc(mk(0, 0, 0, 0, 0, 3'b000, 1), 1'b1, 1'b1, 1'b1, 16'h2222, 1'b0);
        end
    endtask

    task automatic mem_reset(input logic [15:0] ins);
        fetch(ins, 0);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); // DECODE
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); // EXEC
        cyc(mk(0, 1, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); // MEM wait
        // Reset lands during the second MEM cycle: outputs clear in that cycle.
        m_ir  = 16'h0000;
        m_cnt = 16'h0000;
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); // IDLE
    endtask

    // Monitor: compares every cycle for which an expectation is queued.
    always @(negedge clk) begin
        outv_t e;
        outv_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.imem_req = imem_req;
            a.dmem_req = dmem_req;
            a.dmem_we  = dmem_we;
            a.reg_we   = reg_we;
            a.pc_en    = pc_en;
            a.pc_sel   = pc_sel;
            a.halted   = halted;
            a.ir       = ir_out;
`ifdef INSTR_COUNT_EN
            a.cnt      = instr_count;
`else
            a.cnt      = 16'h0000;
            e.cnt      = 16'h0000;
`endif
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL trace[%0d] got ireq=%b dreq=%b we=%b rwe=%b pcen=%b sel=%b halt=%b ir=%h cnt=%h, want ireq=%b dreq=%b we=%b rwe=%b pcen=%b sel=%b halt=%b ir=%h cnt=%h",
                         n_checks, a.imem_req, a.dmem_req, a.dmem_we, a.reg_we, a.pc_en,
                         a.pc_sel, a.halted, a.ir, a.cnt, e.imem_req, e.dmem_req,
                         e.dmem_we, e.reg_we, e.pc_en, e.pc_sel, e.halted, e.ir, e.cnt);
            end
        end else if (drain_req && !drain_done) begin
            drain_done = 1'b1;
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        instr      = 16'h0000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;

        // Reset state, then one IDLE cycle after release
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        cyc(mk(0, 0, 0, 0, 0, 3'b000, 0), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        //   instr     iw dw az  mem st  rwe sel
        run(16'h2345, 0, 0, 0, 0, 0, 1, 3'b000); // ALU 001, ready tied
        run(16'h1234, 2, 0, 1, 0, 0, 1, 3'b000); // ALU 000, 2 fetch waits
        run(16'hC00F, 0, 0, 1, 0, 0, 0, 3'b110); // BEQ taken
        run(16'hC0F0, 1, 0, 0, 0, 0, 0, 3'b000); // BEQ not taken
        run(16'hA55A, 0, 3, 0, 1, 1, 0, 3'b000); // SW, dmem 3 waits
        run(16'h8001, 0, 0, 1, 1, 0, 1, 3'b000); // LW, no wait
        run(16'hE123, 0, 0, 1, 0, 0, 1, 3'b111); // JALR
        run(16'h4ABC, 0, 0, 1, 0, 0, 1, 3'b000); // ALU 010
        mem_reset(16'h9FFF);                     // LW interrupted by reset
        run(16'h2001, 0, 0, 0, 0, 0, 1, 3'b000); // restart after reset
        halt_seq(16'h6000);                      // HALT

        repeat (3) @(negedge clk);
        drain_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port instr, input, 16 bits: instruction word from instruction memory; opcode is instr[15:13].
REQ-004 The block SHALL have port imem_ready, input, 1 bit: instruction memory has valid instr this cycle.
REQ-005 The block SHALL have port dmem_ready, input, 1 bit: data memory has completed the access this cycle.
REQ-006 The block SHALL have port alu_zero, input, 1 bit: ALU equality flag, used by BEQ.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-008 The block SHALL have port dmem_req and port dmem_we, outputs, 1 bit each: data access request and its write qualifier.
REQ-009 The block SHALL have port ir_out, output, 16 bits: latched instruction register.
REQ-010 The block SHALL have port reg_we, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port pc_en, output, 1 bit: program-counter update strobe.
REQ-012 The block SHALL have port pc_sel, output, 3 bits: PC next-address select (3'b000 increment, 3'b110 immediate/BEQ, 3'b111 ALU/JALR).
REQ-013 The block SHALL have port halted, output, 1 bit: high while the sequencer is stopped.

Function
REQ-014 The states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALTED.
REQ-015 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-016 FETCH SHALL hold imem_req=1 until imem_ready=1 is sampled; on that edge it SHALL load instr into ir_out and go to DECODE.
REQ-017 DECODE SHALL last 1 cycle; opcode 3'b011 (HALT) SHALL go to HALTED, all other opcodes to EXEC.
REQ-018 EXEC SHALL last 1 cycle: LW (3'b100) and SW (3'b101) go to MEM; others go to WB.
REQ-019 EXEC SHALL register a branch-taken flag = (opcode==3'b110) AND alu_zero.
REQ-020 MEM SHALL hold dmem_req=1 (dmem_we=1 only for SW) until dmem_ready=1 is sampled, then go to WB.
REQ-021 WB SHALL last 1 cycle and then go to FETCH.
REQ-022 In WB, reg_we SHALL be 1 for ALU opcodes (3'b000-3'b010), LW and JALR; it SHALL be 0 for SW and BEQ.
REQ-023 In WB, pc_en SHALL be 1 for exactly one cycle.
REQ-024 In WB, pc_sel SHALL be 3'b110 if the branch is taken, 3'b111 for JALR, else 3'b000.
REQ-025 Outside WB, pc_en SHALL be 0 and pc_sel SHALL be 3'b000.
REQ-026 HALTED SHALL be terminal until reset: halted=1, and all request/enable outputs 0.
REQ-027 Minimum latency SHALL be 4 cycles for ALU, BEQ and JALR, and 5 cycles for LW/SW, with ready asserted immediately; each wait cycle adds 1.
REQ-028 If imem_ready or dmem_ready is high in a state that does not request it, it SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL force IDLE immediately, at any state including mid-MEM, and abandon the pending request.
REQ-030 Reset values SHALL be: all 1-bit outputs 0, ir_out=16'h0000, pc_sel=3'b000.

Configuration
REQ-031 With INSTR_COUNT_EN defined, output instr_count (16 bits) SHALL be added.
REQ-032 instr_count SHALL reset to 0 and increment on each WB cycle, wrapping from 16'hFFFF to 0.
REQ-033 Without INSTR_COUNT_EN, the instr_count port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the PC_SEL constants (INC=3'b000, IMM=3'b110, ALU=3'b111) and the state enumeration.
REQ-035 The opcode decode SHALL be a combinational sub-module, pc_seq_decode, taking the opcode and producing is_mem, is_store, is_branch, is_jalr, is_halt and writes_reg.

Verification
REQ-036 The bench SHALL check: ALU opcode 3'b001, imem_ready tied 1 -> pc_en and reg_we high in cycle 4 after FETCH entry, pc_sel=3'b000.
REQ-037 The bench SHALL check: BEQ with alu_zero=1 -> WB pc_sel=3'b110, reg_we=0; with alu_zero=0 -> pc_sel=3'b000.
REQ-038 The bench SHALL check: SW with dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, then one WB cycle with reg_we=0.
REQ-039 The bench SHALL check: JALR -> pc_sel=3'b111 and reg_we=1 in WB; HALT -> halted=1 from the cycle after DECODE, with no further imem_req.
REQ-040 The bench SHALL check: reset asserted mid-MEM -> all outputs 0 in the same cycle, then IDLE, then FETCH after release.
